// File: rtl/full_mask_stats.sv
// Per-frame statistics of flagged (flame-colour) pixels: count, bounding box,
// empty flag and a hot-frame streak alarm, published one cycle after eof.
module full_mask_stats #(
  parameter int XW     = 11,
  parameter int YW     = 11,
  parameter int CW     = 22,
  parameter int CONSEC = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_valid,
  input  logic          sof,
  input  logic          eol,
  input  logic          eof,
  input  logic          full,
  input  logic [CW-1:0] thresh,
  output logic          stat_valid,
  output logic [CW-1:0] stat_count,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic          stat_empty,
  output logic          alarm,
  output logic          frame_err
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
  state_t r_state, w_next;

  logic [XW-1:0] r_x, r_xmin, r_xmax;
  logic [YW-1:0] r_y, r_ymin, r_ymax;
  logic [CW-1:0] r_cnt, r_thresh;
  logic [3:0]    r_streak;

  logic          w_take, w_pub, w_err, w_first, w_hot;
  logic [XW-1:0] w_cx, w_nx, w_xmin, w_xmax;
  logic [YW-1:0] w_cy, w_ny, w_ymin, w_ymax;
  logic [CW-1:0] w_bcnt, w_cnt, w_thr;
  logic [3:0]    w_streak;

  // A pixel belongs to a frame if it starts one or arrives while one is open.
  assign w_take = pix_valid && (sof || r_state == S_ACTIVE);
  assign w_pub  = w_take && eof;
  assign w_err  = pix_valid && ((sof && r_state == S_ACTIVE) ||
                                (eof && !sof && r_state == S_IDLE));

  // sof restarts accumulation with this pixel as the first sample.
  assign w_cx    = sof ? '0 : r_x;
  assign w_cy    = sof ? '0 : r_y;
  assign w_bcnt  = sof ? '0 : r_cnt;
  assign w_thr   = sof ? thresh : r_thresh;
  assign w_first = (w_bcnt == '0);
  assign w_cnt   = (full && w_bcnt != '1) ? w_bcnt + 1'b1 : w_bcnt;

  assign w_xmin = (full && (w_first || w_cx < r_xmin)) ? w_cx : r_xmin;
  assign w_xmax = (full && (w_first || w_cx > r_xmax)) ? w_cx : r_xmax;
  assign w_ymin = (full && (w_first || w_cy < r_ymin)) ? w_cy : r_ymin;
  assign w_ymax = (full && (w_first || w_cy > r_ymax)) ? w_cy : r_ymax;

  assign w_nx = eol ? '0 : ((w_cx == '1) ? w_cx : w_cx + 1'b1);
  assign w_ny = (eol && w_cy != '1) ? w_cy + 1'b1 : w_cy;

  assign w_hot    = (w_cnt >= w_thr);
  assign w_streak = !w_hot ? 4'd0 :
                    (r_streak >= 4'(CONSEC)) ? 4'(CONSEC) : r_streak + 4'd1;

  always_comb begin
    w_next = r_state;
    if (w_take) w_next = eof ? S_IDLE : S_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_cnt      <= '0;
      r_thresh   <= '0;
      r_xmin     <= '0;
      r_xmax     <= '0;
      r_ymin     <= '0;
      r_ymax     <= '0;
      r_streak   <= '0;
      stat_valid <= 1'b0;
      stat_count <= '0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      stat_empty <= 1'b0;
      alarm      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      stat_valid <= w_pub;
      frame_err  <= w_err;
      if (w_take) begin
        r_x      <= w_nx;
        r_y      <= w_ny;
        r_cnt    <= w_cnt;
        r_thresh <= w_thr;
        r_xmin   <= w_xmin;
        r_xmax   <= w_xmax;
        r_ymin   <= w_ymin;
        r_ymax   <= w_ymax;
      end
      if (w_pub) begin
        stat_count <= w_cnt;
        stat_empty <= (w_cnt == '0);
        // An empty frame reports a zero bounding box, not stale extents.
        x_min      <= (w_cnt == '0) ? '0 : w_xmin;
        x_max      <= (w_cnt == '0) ? '0 : w_xmax;
        y_min      <= (w_cnt == '0) ? '0 : w_ymin;
        y_max      <= (w_cnt == '0) ? '0 : w_ymax;
        r_streak   <= w_streak;
        alarm      <= (w_streak == 4'(CONSEC));
      end
    end
  end

endmodule

// File: tb/tb_full_mask_stats.sv
// Randomized frame-level bench for full_mask_stats with a frame-array reference model.
module tb_full_mask_stats;
  localparam int XW = 11, YW = 11, CW = 22, CONSEC = 3;

  logic          clk = 1'b0;
  logic          reset, pix_valid, sof, eol, eof, full;
  logic [CW-1:0] thresh;
  logic          stat_valid, stat_empty, alarm, frame_err;
  logic [CW-1:0] stat_count;
  logic [XW-1:0] x_min, x_max;
  logic [YW-1:0] y_min, y_max;

  full_mask_stats #(.XW(XW), .YW(YW), .CW(CW), .CONSEC(CONSEC)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .sof(sof), .eol(eol),
    .eof(eof), .full(full), .thresh(thresh), .stat_valid(stat_valid),
    .stat_count(stat_count), .x_min(x_min), .x_max(x_max), .y_min(y_min),
    .y_max(y_max), .stat_empty(stat_empty), .alarm(alarm), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  bit fl [16][16];
  int m_streak = 0;
  int h_cnt = 0, h_alarm = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) fl[y][x] = 1'b0;
  endtask

  task automatic set_rand(input int w, input int h, input int k);
    int placed = 0;
    clr();
    while (placed < k) begin
      int x = $urandom_range(0, w - 1);
      int y = $urandom_range(0, h - 1);
      if (!fl[y][x]) begin fl[y][x] = 1'b1; placed++; end
    end
  endtask

  task automatic set_density(input int w, input int h, input int pct);
    clr();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) fl[y][x] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic idle_cycle();
    pix_valid = 1'b0;
    sof = 1'($urandom); eol = 1'($urandom); eof = 1'($urandom); full = 1'($urandom);
    thresh = CW'($urandom);
    @(posedge clk); #1;
    chk("idle_sv", 32'(stat_valid), 0);
    chk("idle_err", 32'(frame_err), 0);
    chk("hold_cnt", 32'(stat_count), h_cnt);
    chk("hold_alarm", 32'(alarm), h_alarm);
  endtask

  // Open a frame (from IDLE) and leave it unfinished after n pixels.
  task automatic partial(input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1; sof = (i == 0); eol = (i % 4 == 3); eof = 1'b0;
      full = 1'($urandom); thresh = CW'($urandom);
      @(posedge clk); #1;
      chk("part_sv", 32'(stat_valid), 0);
      chk("part_err", 32'(frame_err), 0);
    end
    pix_valid = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input int thr, input bit err_first);
    int c = 0, x0 = 0, x1 = 0, y0 = 0, y1 = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        if (fl[y][x]) begin
          if (c == 0) begin x0 = x; x1 = x; y0 = y; y1 = y; end
          else begin
            if (x < x0) x0 = x;
            if (x > x1) x1 = x;
            if (y < y0) y0 = y;
            if (y > y1) y1 = y;
          end
          c++;
        end
    if (c >= thr) m_streak = (m_streak < CONSEC) ? m_streak + 1 : CONSEC;
    else          m_streak = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        bit first, last;
        first = (x == 0 && y == 0);
        last  = (x == w - 1 && y == h - 1);
        if (!first) while ($urandom_range(0, 3) == 0) idle_cycle();
        pix_valid = 1'b1; sof = first; eol = (x == w - 1); eof = last; full = fl[y][x];
        thresh = first ? CW'(thr) : CW'($urandom);
        @(posedge clk); #1;
        chk("err", 32'(frame_err), 32'(first && err_first));
        if (last) begin
          h_cnt = c;
          h_alarm = (m_streak == CONSEC);
          chk("sv", 32'(stat_valid), 1);
          chk("count", 32'(stat_count), c);
          chk("x_min", 32'(x_min), x0);
          chk("x_max", 32'(x_max), x1);
          chk("y_min", 32'(y_min), y0);
          chk("y_max", 32'(y_max), y1);
          chk("empty", 32'(stat_empty), 32'(c == 0));
          chk("alarm", 32'(alarm), h_alarm);
        end else chk("sv_mid", 32'(stat_valid), 0);
      end
    pix_valid = 1'b0;
    idle_cycle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sv"}, 32'(stat_valid), 0);
    chk({tag, "_cnt"}, 32'(stat_count), 0);
    chk({tag, "_bbox"}, 32'(x_min) | 32'(x_max) | 32'(y_min) | 32'(y_max), 0);
    chk({tag, "_empty"}, 32'(stat_empty), 0);
    chk({tag, "_alarm"}, 32'(alarm), 0);
  endtask

  initial begin
    reset = 1'b1; pix_valid = 1'b0; sof = 1'b0; eol = 1'b0; eof = 1'b0; full = 1'b0;
    thresh = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    chk("rst_err", 32'(frame_err), 0);
    reset = 1'b0;
    idle_cycle();

    // 4x3 frame, two flagged pixels
    clr(); fl[0][1] = 1'b1; fl[2][2] = 1'b1;
    send_frame(4, 3, 1, 1'b0);
    // empty frame clears the streak
    clr();
    send_frame(4, 3, 1, 1'b0);
    // streak: four hot frames then one cool frame
    for (int i = 0; i < 4; i++) begin
      set_rand(4, 3, 5);
      send_frame(4, 3, 5, 1'b0);
    end
    set_rand(4, 3, 4);
    send_frame(4, 3, 5, 1'b0);
    // single-pixel frame
    clr(); fl[0][0] = 1'b1;
    send_frame(1, 1, 1, 1'b0);
    // abort after 6 pixels, restart frame
    partial(6);
    set_density(4, 3, 50);
    send_frame(4, 3, 2, 1'b1);

    repeat (30) begin
      int w, h;
      bit ab;
      w = $urandom_range(1, 8);
      h = $urandom_range(1, 6);
      ab = ($urandom_range(0, 4) == 0);
      if (ab) partial($urandom_range(1, 5));
      set_density(w, h, $urandom_range(0, 100));
      send_frame(w, h, $urandom_range(0, w * h), ab);
    end

    // reset mid-frame with simultaneous pixel events, then orphan eof
    partial(3);
    reset = 1'b1; pix_valid = 1'b1; sof = 1'b1; eol = 1'b1; eof = 1'b1; full = 1'b1;
    @(posedge clk); #1;
    chk_zero("mid_rst");
    chk("mid_rst_err", 32'(frame_err), 0);
    reset = 1'b0; m_streak = 0; h_cnt = 0; h_alarm = 0;
    pix_valid = 1'b1; sof = 1'b0; eol = 1'b1; eof = 1'b1; full = 1'b1;
    @(posedge clk); #1;
    chk("orph_err", 32'(frame_err), 1);
    chk_zero("orph");
    idle_cycle();
    set_density(3, 2, 60);
    send_frame(3, 2, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/full_mask_stats.md
FULL_MASK_STATS -- requirements
Module: full_mask_stats

Interface
REQ-001 Parameter: XW, 11, width of the column counter and x outputs.
REQ-002 Parameter: YW, 11, width of the row counter and y outputs.
REQ-003 Parameter: CW, 22, width of the flagged-pixel counter and threshold.
REQ-004 Parameter: CONSEC, 3, number of consecutive hot frames needed to raise alarm (1..15).
REQ-005 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: pix_valid  input  1  qualifies sof, eol, eof and full for this cycle.
REQ-008 Port: sof  input  1  first pixel of a frame.
REQ-009 Port: eol  input  1  last pixel of a line.
REQ-010 Port: eof  input  1  last pixel of a frame.
REQ-011 Port: full  input  1  per-pixel flame-colour flag from the upstream colour classifier.
REQ-012 Port: thresh  input  CW  hot-frame pixel threshold, sampled on the accepted sof pixel.
REQ-013 Port: stat_valid  output  1  one-cycle pulse when frame results update.
REQ-014 Port: stat_count  output  CW  flagged pixels in the last completed frame.
REQ-015 Port: x_min, x_max  output  XW each  bounding-box columns of flagged pixels.
REQ-016 Port: y_min, y_max  output  YW each  bounding-box rows of flagged pixels.
REQ-017 Port: stat_empty  output  1  last completed frame had zero flagged pixels.
REQ-018 Port: alarm  output  1  hot-frame streak has reached CONSEC.
REQ-019 Port: frame_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-020 States: IDLE (waiting for sof) and ACTIVE (accumulating); inputs other than sof are ignored in IDLE.
REQ-021 Accepted pixel = pix_valid high; cycles with pix_valid low change no state.
REQ-022 On accepted sof: pixel coordinate is (0,0); count and bbox restart with this pixel as the first sample; thresh latched; state -> ACTIVE.
REQ-023 After each accepted pixel: eol high -> x=0, y=y+1; else x=x+1; x and y saturate at all-ones.
REQ-024 full high on accepted pixel: count +1, saturating at 2^CW-1; bbox min/max updated with the current (x,y), first flagged pixel initialises all four.
REQ-025 On accepted eof in ACTIVE: next cycle stat_valid=1 for exactly one cycle, and stat_count, bbox, stat_empty and alarm update on that cycle; state -> IDLE.
REQ-026 Latency: stat outputs change exactly 1 cycle after the eof pixel; they then hold until the next publish.
REQ-027 sof and eof on the same accepted pixel: treated as a one-pixel frame and published.
REQ-028 Empty frame (count 0): stat_empty=1 and x_min, x_max, y_min, y_max=0.
REQ-029 Hot frame: stat_count >= latched thresh; thresh=0 makes every frame hot.
REQ-030 Streak counter: +1 per hot frame, saturating at CONSEC; cleared by any non-hot frame; alarm=1 iff streak equals CONSEC.
REQ-031 sof while ACTIVE: frame_err pulses; the partial frame is discarded unpublished; the new frame starts.
REQ-032 eof while IDLE without sof: frame_err pulses; nothing is published.
REQ-033 frame_err pulses 1 cycle after the offending pixel and never coincides with a discarded-frame stat_valid.

Reset
REQ-034 While reset is high at a clock edge: state -> IDLE; x, y, count and streak -> 0; all outputs -> 0.
REQ-035 Reset mid-frame discards the frame; no stat_valid occurs until a complete sof..eof frame follows reset release.
REQ-036 Reset has priority over all simultaneous pixel events.

Verification
REQ-037 4x3 frame, full only at (1,0) and (2,2), thresh=1 -> stat_valid 1 cycle after eof; count=2; x 1..2; y 0..2; stat_empty=0.
REQ-038 4x3 frame, full never high -> count=0, stat_empty=1, bbox=0, streak cleared, alarm=0.
REQ-039 CONSEC=3, four frames each count=5, thresh=5 -> alarm 0,0,1,1; fifth frame count=4 -> alarm 0.
REQ-040 sof at pixel 6 of an unfinished frame -> frame_err pulse, no stat_valid; the next completed frame reports only its own pixels.
REQ-041 Single pixel with sof=eof=full=1 -> count=1, bbox (0,0)-(0,0), stat_valid next cycle.
REQ-042 Reset asserted mid-frame, then eof without sof -> frame_err pulse, outputs remain 0, no stat_valid.
